// File: rtl/wb_async_multi_bridge.sv
// wb_async_multi_bridge
//   Bridges one pipelined Wishbone slave port to NUM_CHANNELS asynchronous
//   request/ack peripherals that share one address bus and one data bus.
//   The upper wb_addr_i bits select the channel and the lower bits form the
//   async address. Only one transaction is in flight at a time. The bridge
//   runs a full four-phase handshake: raise the request, wait for ack high,
//   drop the request, then wait for ack low.
//
// Optional feature (define WB_ASYNC_TIMEOUT_EN):
//   A request that sees no synchronised ack within TIMEOUT_CYCLES is
//   terminated with a one-cycle wb_err_o pulse. Without the macro,
//   wb_err_o is tied 0 and a request waits for its ack indefinitely.
//
// Ports:
//   wb_clk_i, wb_reset_i   sole clock; synchronous active-high reset
//   wb_addr_i              {channel, async address}
//   wb_data_i / wb_data_o  write data / read data (valid with wb_ack_o)
//   wb_write_i, wb_strobe_i, wb_stall_o, wb_ack_o, wb_err_o
//                          pipelined Wishbone handshake
//   read_only_i            per-channel write suppression, sampled at accept
//   ab_read_req_o          one-hot read request
//   ab_write_req_o         one-hot write request
//   ab_ack_i               raw, unsynchronised acks
//   ab_addr_o              shared async address
//   ab_data_io             shared data bus, driven only during a write request
module wb_async_multi_bridge #(
    parameter int ADDR_BITS      = 5,
    parameter int DATA_BITS      = 8,
    parameter int NUM_CHANNELS   = 4,
    parameter int CH_BITS        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_reset_i,
    input  logic [CH_BITS+ADDR_BITS-1:0] wb_addr_i,
    input  logic [DATA_BITS-1:0]         wb_data_i,
    output logic [DATA_BITS-1:0]         wb_data_o,
    input  logic                         wb_write_i,
    input  logic                         wb_strobe_i,
    output logic                         wb_stall_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    input  logic [NUM_CHANNELS-1:0]      read_only_i,
    output logic [NUM_CHANNELS-1:0]      ab_read_req_o,
    output logic [NUM_CHANNELS-1:0]      ab_write_req_o,
    input  logic [NUM_CHANNELS-1:0]      ab_ack_i,
    output logic [ADDR_BITS-1:0]         ab_addr_o,
    inout  wire  [DATA_BITS-1:0]         ab_data_io
);

    generate
        if (SYNC_STAGES < 2 || NUM_CHANNELS < 1 || NUM_CHANNELS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("wb_async_multi_bridge: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DONE, REQ, RELEASE} state_t;

    state_t                  state;
    logic [CH_BITS-1:0]      ch_q;
    logic [DATA_BITS-1:0]    wdata_q;
    logic                    write_q;
    logic [NUM_CHANNELS-1:0] sync_q [SYNC_STAGES];

    logic [CH_BITS-1:0]      req_ch;
    logic                    req_in_range;
    logic                    ch_q_in_range;
    logic [NUM_CHANNELS-1:0] sel_onehot;
    logic                    ack_sync;

`ifdef WB_ASYNC_TIMEOUT_EN
    localparam int TO_RAW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_BITS = (TO_RAW < 8) ? 8 : ((TO_RAW > 32) ? 32 : TO_RAW);
    logic [TO_BITS-1:0] timeout_cnt;
`endif

    assign req_ch        = wb_addr_i[CH_BITS+ADDR_BITS-1 -: CH_BITS];
    assign req_in_range  = int'(req_ch) < NUM_CHANNELS;
    assign ch_q_in_range = int'(ch_q) < NUM_CHANNELS;
    assign sel_onehot    = NUM_CHANNELS'(1) << req_ch;

    // Only the latched channel's ack matters; the other channels' acks are ignored.
    assign ack_sync   = ch_q_in_range ? sync_q[SYNC_STAGES-1][ch_q] : 1'b0;
    assign wb_stall_o = (state != IDLE);

    // The bus is released on the same edge the write request drops.
    assign ab_data_io = (|ab_write_req_o) ? wdata_q : 'z;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= ab_ack_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state          <= IDLE;
            ch_q           <= '0;
            wdata_q        <= '0;
            write_q        <= 1'b0;
            ab_addr_o      <= '0;
            ab_read_req_o  <= '0;
            ab_write_req_o <= '0;
            wb_ack_o       <= 1'b0;
            wb_err_o       <= 1'b0;
            wb_data_o      <= '0;
`ifdef WB_ASYNC_TIMEOUT_EN
            timeout_cnt    <= '0;
`endif
        end else begin
            // Completion pulses default low so each lasts exactly one cycle.
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_strobe_i) begin
                        ch_q      <= req_ch;
                        ab_addr_o <= wb_addr_i[ADDR_BITS-1:0];
                        wdata_q   <= wb_data_i;
                        write_q   <= wb_write_i;
                        if (!req_in_range || (wb_write_i && read_only_i[req_ch])) begin
                            state <= DONE;
                        end else begin
                            state <= REQ;
                            if (wb_write_i) ab_write_req_o <= sel_onehot;
                            else            ab_read_req_o  <= sel_onehot;
`ifdef WB_ASYNC_TIMEOUT_EN
                            timeout_cnt <= '0;
`endif
                        end
                    end
                end
                // Suppressed write or unmapped channel: acknowledge with no bus cycle.
                DONE: begin
                    wb_ack_o <= 1'b1;
                    if (!write_q && !ch_q_in_range) wb_data_o <= '0;
                    state <= IDLE;
                end
                REQ: begin
                    // An ack arriving on the timeout cycle wins over the error.
                    if (ack_sync) begin
                        if (!write_q) wb_data_o <= ab_data_io;
                        wb_ack_o       <= 1'b1;
                        ab_read_req_o  <= '0;
                        ab_write_req_o <= '0;
                        state          <= RELEASE;
                    end
`ifdef WB_ASYNC_TIMEOUT_EN
                    else if (timeout_cnt == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
                        wb_err_o       <= 1'b1;
                        ab_read_req_o  <= '0;
                        ab_write_req_o <= '0;
                        state          <= RELEASE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
`endif
                end
                // Four-phase release: wait for the peripheral to drop its ack.
                RELEASE: begin
                    if (!ack_sync) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_async_multi_bridge.sv
`timescale 1ns/1ps
module tb_wb_async_multi_bridge;

    localparam int ADDR_BITS      = 5;
    localparam int DATA_BITS      = 8;
    localparam int NUM_CHANNELS   = 4;
    localparam int CH_BITS        = 2;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 16;

    typedef struct {
        logic       err;
        logic       chk;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] wb_addr;
    logic [7:0] wb_wdata;
    logic [7:0] wb_rdata;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_stall;
    logic       wb_ack;
    logic       wb_err;
    logic [3:0] read_only;
    logic [3:0] rd_req;
    logic [3:0] wr_req;
    logic [3:0] ab_ack;
    logic [4:0] ab_addr;
    wire  [7:0] ab_data;

    logic [7:0] per_rdata = 8'h00;
    logic [3:0] silent    = 4'b0000;
    logic [3:0] stuck     = 4'b0000;
    int         ack_delay = 3;
    logic [7:0] exp_wdata = 8'h00;

    always #5 clk = ~clk;

    // Peripheral model drives read data whenever any read request is up.
    assign ab_data = (|rd_req) ? per_rdata : 'z;

    wb_async_multi_bridge #(
        .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .NUM_CHANNELS(NUM_CHANNELS),
        .CH_BITS(CH_BITS), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .wb_clk_i(clk), .wb_reset_i(rst), .wb_addr_i(wb_addr), .wb_data_i(wb_wdata),
        .wb_data_o(wb_rdata), .wb_write_i(wb_we), .wb_strobe_i(wb_stb),
        .wb_stall_o(wb_stall), .wb_ack_o(wb_ack), .wb_err_o(wb_err),
        .read_only_i(read_only), .ab_read_req_o(rd_req), .ab_write_req_o(wr_req),
        .ab_ack_i(ab_ack), .ab_addr_o(ab_addr), .ab_data_io(ab_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        check_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    endtask

    // Async peripherals: ack rises ack_delay cycles after request, falls one
    // cycle after the request drops. Silent channels never ack; stuck ones hold ack.
    initial begin
        int cnt [4];
        ab_ack = '0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        forever begin
            @(posedge clk); #1;
            for (int ch = 0; ch < 4; ch++) begin
                if (stuck[ch]) begin
                    ab_ack[ch] = 1'b1;
                end else if ((rd_req[ch] || wr_req[ch]) && !silent[ch]) begin
                    if (cnt[ch] >= ack_delay) ab_ack[ch] = 1'b1;
                    else cnt[ch]++;
                end else begin
                    cnt[ch]    = 0;
                    ab_ack[ch] = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every completion, checks bus protocol.
    always @(negedge clk) begin
        if (wb_ack === 1'b1 || wb_err === 1'b1) begin
            check("resp_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_kind", {30'd0, wb_ack, wb_err}, {30'd0, ~e.err, e.err});
                if (e.chk) check("read_data", 32'(wb_rdata), 32'(e.data));
            end
        end
        if (|(rd_req | wr_req)) begin
            check("req_onehot", 32'($countones(rd_req | wr_req)), 32'd1);
            check("no_foreign_ack", 32'(ab_ack & ~(rd_req | wr_req)), 32'd0);
        end
        if (|wr_req) check("write_bus", 32'(ab_data), 32'(exp_wdata));
    end

    task automatic issue(input int ch, input logic [4:0] a, input logic we, input logic [7:0] d);
        logic st;
        bit   done;
        done     = 1'b0;
        wb_addr  = {2'(ch), a};
        wb_we    = we;
        wb_wdata = d;
        wb_stb   = 1'b1;
        if (we) exp_wdata = d;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            st = wb_stall;
            @(posedge clk); #1;
            if (!st) done = 1'b1;
        end
        wb_stb = 1'b0;
        check("accept_in_time", 32'(done), 32'd1);
    endtask

    task automatic wait_resp();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (wb_ack || wb_err) seen = 1'b1;
        end
        check("resp_in_time", 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            if (!wb_stall) idle = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("idle_in_time", 32'(idle), 32'd1);
    endtask

    initial begin
        rst = 1'b1; wb_stb = 1'b0; wb_addr = '0; wb_we = 1'b0; wb_wdata = '0; read_only = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(wb_stall), 32'd0);
        check("rst_ack_err", {30'd0, wb_ack, wb_err}, 32'd0);
        check("rst_reqs", {24'd0, rd_req, wr_req}, 32'd0);
        check("rst_addr_data", {19'd0, ab_addr, wb_rdata}, 32'd0);
        check("rst_bus_hiz", 32'(ab_data === 8'hzz), 32'd1);
        rst = 1'b0;

        // Read ch2 address 0x05.
        per_rdata = 8'hA7;
        exp_q.push_back('{1'b0, 1'b1, 8'hA7});
        issue(2, 5'h05, 1'b0, 8'h00);
        check("rd_req_ch2", 32'(rd_req), 32'b0100);
        check("rd_no_wr", 32'(wr_req), 32'd0);
        check("rd_addr", 32'(ab_addr), 32'h05);
        check("rd_stall", 32'(wb_stall), 32'd1);
        wait_resp();
        check("stall_in_release", 32'(wb_stall), 32'd1);
        check("rd_req_dropped", 32'(rd_req), 32'd0);
        @(posedge clk); #1;
        check("ack_one_pulse", 32'(wb_ack), 32'd0);
        wait_idle();
        check("idle_after_ack_low", 32'(ab_ack[2]), 32'd0);

        // Write 0x3C to ch1; read data register stays 0xA7.
        exp_q.push_back('{1'b0, 1'b1, 8'hA7});
        issue(1, 5'h0A, 1'b1, 8'h3C);
        check("wr_req_ch1", 32'(wr_req), 32'b0010);
        check("wr_bus_value", 32'(ab_data), 32'h3C);
        wait_resp();
        wait_idle();
        check("wr_bus_released", 32'(ab_data === 8'hzz), 32'd1);

        // Write to a read-only channel: ack at T+1, no request, bus idle.
        read_only = 4'b0010;
        exp_q.push_back('{1'b0, 1'b1, 8'hA7});
        issue(1, 5'h03, 1'b1, 8'h55);
        check("ro_no_req", {24'd0, rd_req, wr_req}, 32'd0);
        check("ro_no_ack_yet", 32'(wb_ack), 32'd0);
        @(posedge clk); #1;
        check("ro_ack_t1", 32'(wb_ack), 32'd1);
        check("ro_still_no_req", {24'd0, rd_req, wr_req}, 32'd0);
        check("ro_bus_hiz", 32'(ab_data === 8'hzz), 32'd1);
        wait_idle();
        read_only = 4'b0000;

        // Back-to-back: ch0 read then ch3 write; the second waits for release.
        per_rdata = 8'h11;
        exp_q.push_back('{1'b0, 1'b1, 8'h11});
        issue(0, 5'h01, 1'b0, 8'h00);
        exp_q.push_back('{1'b0, 1'b1, 8'h11});
        issue(3, 5'h02, 1'b1, 8'h99);
        check("b2b_ch0_ack_low", 32'(ab_ack[0]), 32'd0);
        check("b2b_wr_req_ch3", 32'(wr_req), 32'b1000);
        check("b2b_addr", 32'(ab_addr), 32'h02);
        wait_resp();
        wait_idle();

        // Ack already high at accept: completes at once, release waits for ack low.
        stuck[2]  = 1'b1;
        per_rdata = 8'h5A;
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back('{1'b0, 1'b1, 8'h5A});
        issue(2, 5'h1F, 1'b0, 8'h00);
        wait_resp();
        repeat (5) @(posedge clk);
        #1;
        check("stuck_release_waits", 32'(wb_stall), 32'd1);
        stuck[2] = 1'b0;
        wait_idle();

        // Silent channel 0.
        silent[0] = 1'b1;
`ifdef WB_ASYNC_TIMEOUT_EN
        exp_q.push_back('{1'b1, 1'b0, 8'h00});
        issue(0, 5'h04, 1'b0, 8'h00);
        repeat (15) @(posedge clk);
        #1;
        check("to_no_err_early", 32'(wb_err), 32'd0);
        check("to_req_held", 32'(rd_req), 32'b0001);
        @(posedge clk); #1;
        check("to_err_pulse", {30'd0, wb_ack, wb_err}, 32'd1);
        check("to_req_dropped", 32'(rd_req), 32'd0);
        check("to_data_unchanged", 32'(wb_rdata), 32'h5A);
        wait_idle();
`else
        issue(0, 5'h04, 1'b0, 8'h00);
        repeat (60) @(posedge clk);
        #1;
        check("no_to_req_held", 32'(rd_req), 32'b0001);
        check("no_to_stall", 32'(wb_stall), 32'd1);
`endif

        // Reset in the middle of a request.
        if (!wb_stall) issue(0, 5'h04, 1'b0, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_req", 32'(rd_req), 32'b0001);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_reqs", {24'd0, rd_req, wr_req}, 32'd0);
        check("mid_rst_ack_err", {30'd0, wb_ack, wb_err}, 32'd0);
        check("mid_rst_idle", 32'(wb_stall), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        silent[0] = 1'b0;

        // Recovery read on the top channel at the top address.
        per_rdata = 8'hC3;
        exp_q.push_back('{1'b0, 1'b1, 8'hC3});
        issue(3, 5'h1F, 1'b0, 8'h00);
        check("rec_req_ch3", 32'(rd_req), 32'b1000);
        check("rec_addr", 32'(ab_addr), 32'h1F);
        wait_resp();
        wait_idle();

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", pass_cnt, check_cnt);
        $fatal(1);
    end

endmodule
